risc_v_mem_arb: RTL
===================

RISC_V_MEM_ARB -- requirements
Module: risc_v_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive LS grants while IF is pending.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port if_req, input, 1: instruction-fetch request; held high until if_valid.
REQ-005 SHALL have port if_addr, input, 32: fetch byte address; stable while if_req is high.
REQ-006 SHALL have port if_rdata, output, 32: fetched word.
REQ-007 SHALL have port if_valid, output, 1: one-cycle pulse marking if_rdata valid.
REQ-008 SHALL have port ls_req, input, 1: load/store request; held high until ls_valid.
REQ-009 SHALL have port ls_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have port ls_addr, input, 32: load/store byte address.
REQ-011 SHALL have port ls_wdata, input, 32: store data.
REQ-012 SHALL have port ls_be, input, 4: store byte enables.
REQ-013 SHALL have port ls_rdata, output, 32: load data.
REQ-014 SHALL have port ls_valid, output, 1: one-cycle completion pulse for loads and stores.
REQ-015 SHALL have ports mem_en, mem_we (output, 1), mem_be (output, 4), mem_addr (output, 32) and mem_wdata (output, 32), all driven to the single-port synchronous memory.
REQ-016 SHALL have port mem_rdata, input, 32: memory read data, valid in the cycle after mem_en.
REQ-017 SHALL have port busy, output, 1: high when the FSM is not in IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and RESP, with all mem_* outputs registered.
REQ-019 SHALL, in IDLE or RESP, select a winner from the pending requests that have not yet completed and go to ACCESS; otherwise it SHALL go to IDLE.
REQ-020 SHALL, in ACCESS, assert mem_en for exactly one cycle, carrying the winner's address, data, we and be.
  - An IF access SHALL drive mem_we=0 and mem_be=4'hF.
REQ-021 SHALL, in RESP, capture mem_rdata into the winner's rdata output and pulse the winner's valid for one cycle.
  - Stores SHALL pulse ls_valid and leave ls_rdata unchanged.
REQ-022 SHALL produce latency: request seen in IDLE at cycle N -> mem_en at N+1 -> valid at N+2.
  - Back-to-back accesses SHALL give a sustained throughput of one access per 2 cycles.
REQ-023 SHALL treat a request as pending in the cycle its valid pulses only if the requester keeps req high into the following cycle.
REQ-024 SHALL give LS priority over IF.
  - If IF is pending and LS has won STARVE_MAX consecutive grants, IF SHALL win the next arbitration.
REQ-025 SHALL use a 3-bit starvation counter:
  - incremented on each LS grant while if_req is high;
  - cleared on every IF grant and whenever if_req is low at arbitration;
  - saturating at STARVE_MAX.
REQ-026 SHALL latch the winner's request fields at arbitration; later input changes SHALL NOT affect an access in flight.
REQ-027 SHALL hold if_rdata and ls_rdata between valid pulses.
REQ-028 SHALL ensure if_valid and ls_valid are never high in the same cycle, and mem_en is never high in two consecutive cycles.
REQ-029 SHALL ignore a request deasserted before its grant (no access is issued for it).

Reset
REQ-030 SHALL, while rst_n is low, immediately force:
  - the FSM to IDLE;
  - mem_en, mem_we, if_valid, ls_valid and busy to 0;
  - mem_be to 0; mem_addr, mem_wdata, if_rdata and ls_rdata to 0;
  - the starvation counter to 0.
REQ-031 SHALL abandon an access in flight when reset is asserted mid-operation: no valid pulse follows, and after release the requester re-arbitrates from IDLE.
REQ-032 SHALL allow arbitration in the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL pass the scenario: if_req=1, if_addr=0x10, memory word 0x00500093 -> mem_en at N+1 with addr 0x10, if_valid pulse at N+2 with if_rdata=0x00500093.
REQ-034 SHALL pass the scenario: if_req and ls_req (load, addr 0x100) rise together -> LS granted first, ls_valid at N+2, then IF access, if_valid at N+4.
REQ-035 SHALL pass the scenario: store ls_addr=0x200, ls_wdata=0xDEADBEEF, ls_be=4'b0011 -> one cycle with mem_en=1, mem_we=1, mem_be=4'b0011; ls_valid pulses; a subsequent load of 0x200 returns the lower halfword 0xBEEF.
REQ-036 SHALL pass the scenario: ls_req held high continuously, if_req high -> the grant sequence is LS,LS,LS,LS,IF,LS... with STARVE_MAX=4.
REQ-037 SHALL pass the scenario: rst_n pulled low during ACCESS -> all outputs are 0 within the same cycle, no valid pulse, and the access is re-issued after release with the request still high.
REQ-038 SHALL pass the scenario: ls_req pulses high then low before grant while IF is in flight -> no LS memory access and no ls_valid.

Source files
------------

// File: rtl/risc_v_mem_arb.sv
`default_nettype none
// risc_v_mem_arb: arbitrates IF and LS requests onto one single-port synchronous memory,
// LS-priority with bounded IF starvation. Rev 1.0
module risc_v_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] C_STARVE_MAX = 3'(STARVE_MAX);

  state_t      r_state;
  logic [2:0]  r_starve;
  logic        r_win_ls;
  logic        r_win_we;
  logic        r_busy;
  logic        r_if_valid;
  logic        r_ls_valid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_arb_slot;
  logic        w_if_forced;
  logic        w_grant_ls;
  logic        w_grant_if;
  logic [2:0]  w_starve_inc;

  // Arbitration happens in every non-ACCESS cycle, so a RESP cycle can launch the next access.
  assign w_arb_slot   = (r_state != ST_ACCESS);
  assign w_if_forced  = if_req && (r_starve >= C_STARVE_MAX);
  assign w_grant_ls   = w_arb_slot && ls_req && !w_if_forced;
  assign w_grant_if   = w_arb_slot && if_req && !w_grant_ls;
  assign w_starve_inc = (r_starve >= C_STARVE_MAX) ? r_starve : r_starve + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_starve    <= 3'd0;
      r_win_ls    <= 1'b0;
      r_win_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_if_valid  <= 1'b0;
      r_ls_valid  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_ls_rdata  <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      case (r_state)
        ST_ACCESS: begin
          r_state    <= ST_RESP;
          r_busy     <= 1'b1;
          r_if_valid <= !r_win_ls;
          r_ls_valid <= r_win_ls;
        end
        default: begin
          if (r_state == ST_RESP) begin
            if (!r_win_ls) begin
              r_if_rdata <= mem_rdata;
            end else if (!r_win_we) begin
              r_ls_rdata <= mem_rdata;
            end
          end
          if (w_grant_ls) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_win_ls    <= 1'b1;
            r_win_we    <= ls_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= ls_we;
            r_mem_be    <= ls_be;
            r_mem_addr  <= ls_addr;
            r_mem_wdata <= ls_wdata;
          end else if (w_grant_if) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_win_ls    <= 1'b0;
            r_win_we    <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'hF;
            r_mem_addr  <= if_addr;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          if (!if_req || w_grant_if) begin
            r_starve <= 3'd0;
          end else if (w_grant_ls) begin
            r_starve <= w_starve_inc;
          end
        end
      endcase
    end
  end

  // Read data is forwarded straight from memory during the valid pulse, then held.
  assign if_rdata  = r_if_valid ? mem_rdata : r_if_rdata;
  assign ls_rdata  = (r_ls_valid && !r_win_we) ? mem_rdata : r_ls_rdata;
  assign if_valid  = r_if_valid;
  assign ls_valid  = r_ls_valid;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire
